seq_averager: RTL and testbench
===============================

// Module: seq_averager
// PURPOSE
//  Streaming unsigned averager: accepts a run-time count of samples over a valid/ready input,
//  accumulates at full precision, then divides by the count in a bit-serial divider.
//  Generalises the fixed 8-input add/divide datapath to a parametrised sample width and depth,
//  with handshaking and a multi-cycle divide. Sits between sample producers and result consumers.
// PARAMETERS
//  DATA_W       16  sample and average width (unsigned)
//  MAX_SAMPLES   8  largest legal sample count per run
//  CNT_W  (local) $clog2(MAX_SAMPLES+1)  count width
//  ACC_W  (local) DATA_W+CNT_W           accumulator/dividend width
// PORTS
//  Clk        in   1       clock, rising edge
//  Rst        in   1       reset, asynchronous, active-low
//  start      in   1       begin a run; sampled only in IDLE
//  num        in   CNT_W   sample count for the run; latched with start
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block accepts a sample this cycle
//  in_data    in   DATA_W  sample
//  out_valid  out  1       avg valid; held until out_ready
//  out_ready  in   1       consumer accepts avg
//  avg        out  DATA_W  floor(sum/num) (rounded if AVG_ROUND_EN)
//  busy       out  1       state != IDLE
//  err_num    out  1       one-cycle pulse: start with illegal num
// BEHAVIOUR
//  Clock Clk; reset asynchronous, active-low on Rst. Reset: state IDLE; in_ready, out_valid,
//   busy, err_num = 0; avg, accumulator, counter, latched num = 0. Reset mid-run aborts, no output.
//  FSM IDLE -> ACCUM -> DIV -> DONE -> IDLE.
//  IDLE: start=1 & 1<=num<=MAX_SAMPLES: latch num, clear acc/count, -> ACCUM next cycle.
//   start=1 & (num==0 | num>MAX_SAMPLES): err_num=1 next cycle for one cycle; stay IDLE.
//  ACCUM: in_ready=1. Each in_valid&in_ready: acc += zero-extended in_data, count++.
//   Accept of sample number num -> DIV (in_ready drops next cycle). in_valid gaps allowed.
//  DIV: restoring divide, one quotient bit per cycle, ACC_W cycles, dividend acc, divisor num.
//   Quotient always fits DATA_W (acc <= num*(2^DATA_W-1)); low DATA_W bits -> avg. -> DONE.
//  DONE: out_valid=1, avg stable; out_valid&out_ready -> IDLE, out_valid=0 next cycle.
//  Latency: last sample accepted at edge t -> out_valid high after edge t+ACC_W+1.
//  start ignored while busy (including the out handshake cycle); a new start is sampled
//   in IDLE, so back-to-back runs have one IDLE cycle between them.
//  num changes after latch have no effect on the run in progress.
//  All arithmetic unsigned; no overflow possible at any legal count.
// CONFIGURATION
//  AVG_ROUND_EN defined: dividend = acc + (num>>1) -> round-half-up; still fits ACC_W,
//   quotient still fits DATA_W. Undefined: dividend = acc -> truncating floor. Latency identical.
// STRUCTURE
//  Package seq_averager_pkg: state enum (IDLE, ACCUM, DIV, DONE), CNT_W/ACC_W helper functions.
//  Sub-module seq_divider #(ACC_W, CNT_W): start/done bit-serial restoring divider, ACC_W cycles;
//   top holds FSM, accumulator, counter and handshakes.
// TESTING
//  num=8, samples 10,20..80, out_ready=1 -> avg=45 (0x002D), out_valid 1 cycle at t+ACC_W+1.
//  num=2, samples 1,2 -> avg=1 without AVG_ROUND_EN, avg=2 with it.
//  num=0 and num=9 with start -> err_num one-cycle pulse each, in_ready stays 0, busy 0.
//  num=8, all samples 0xFFFF, in_valid toggled every other cycle -> avg=0xFFFF, count exact.
//  out_ready held 0 for 5 cycles in DONE -> avg/out_valid stable; start during that ignored.
//  Rst asserted after 3 of 5 samples -> immediate IDLE, outputs 0; new run num=1, sample 7 -> avg=7.

Source files
------------

// File: rtl/seq_averager_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_averager_pkg: state encoding and width helpers for seq_averager |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package seq_averager_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DIV   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int cnt_width(input int max_samples);
        return $clog2(max_samples + 1);
    endfunction

    function automatic int acc_width(input int data_w, input int max_samples);
        return data_w + cnt_width(max_samples);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_divider: bit-serial restoring divider, one quotient bit/cycle,  |
// | ACC_W cycles from start to done.          Revision: 1.0            |
// +--------------------------------------------------------------------+
module seq_divider #(
    parameter int ACC_W = 20,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [ACC_W-1:0] quotient
);

    localparam int ITER_W = $clog2(ACC_W + 1);
    localparam logic [ITER_W-1:0] ITERS_AFTER_START = ITER_W'(ACC_W - 1);

    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_div;
    logic [ACC_W-1:0]  r_quo;
    logic [ITER_W-1:0] r_left;
    logic              r_busy;
    logic              r_done;

    logic [CNT_W-1:0]  w_rem_in;
    logic [ACC_W-1:0]  w_quo_in;
    logic [CNT_W-1:0]  w_div_in;
    logic [CNT_W:0]    w_shift;
    logic [CNT_W-1:0]  w_rem_next;
    logic [ACC_W-1:0]  w_quo_next;

    // The start cycle performs the first iteration directly on the fresh operands.
    always_comb begin
        w_rem_in   = start ? '0 : r_rem;
        w_quo_in   = start ? dividend : r_quo;
        w_div_in   = start ? divisor : r_div;
        w_shift    = {w_rem_in, w_quo_in[ACC_W-1]};
        w_rem_next = w_shift[CNT_W-1:0];
        w_quo_next = {w_quo_in[ACC_W-2:0], 1'b0};
        if (w_shift >= {1'b0, w_div_in}) begin
            w_rem_next    = CNT_W'(w_shift - {1'b0, w_div_in});
            w_quo_next[0] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_left <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_div  <= divisor;
                r_left <= ITERS_AFTER_START;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_left <= r_left - 1'b1;
                if (r_left == ITER_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/seq_averager.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_averager: streaming unsigned averager with valid/ready ports.  |
// | Define AVG_ROUND_EN for round-half-up.    Revision: 1.0            |
// +--------------------------------------------------------------------+
module seq_averager
    import seq_averager_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MAX_SAMPLES = 8,
    localparam int CNT_W      = cnt_width(MAX_SAMPLES),
    localparam int ACC_W      = acc_width(DATA_W, MAX_SAMPLES)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] avg,
    output logic              busy,
    output logic              err_num
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

    state_t            r_state;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_count;
    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_avg;
    logic              r_div_go;
    logic              r_err;

    logic              w_num_ok;
    logic [CNT_W-1:0]  w_count_inc;
    logic [ACC_W-1:0]  w_dividend;
    logic              w_div_done;
    logic [ACC_W-1:0]  w_quotient;

    assign w_num_ok    = (num != '0) && (num <= MAX_CNT);
    assign w_count_inc = r_count + 1'b1;

`ifdef AVG_ROUND_EN
    // Adding num/2 before the floor divide gives round-half-up.
    assign w_dividend = r_acc + ACC_W'(r_num >> 1);
`else
    assign w_dividend = r_acc;
`endif

    seq_divider #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_div (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (r_div_go),
        .dividend (w_dividend),
        .divisor  (r_num),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= ST_IDLE;
            r_num    <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_avg    <= '0;
            r_div_go <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err    <= 1'b0;
            r_div_go <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_num_ok) begin
                            r_num   <= num;
                            r_acc   <= '0;
                            r_count <= '0;
                            r_state <= ST_ACCUM;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_acc   <= r_acc + ACC_W'(in_data);
                        r_count <= w_count_inc;
                        if (w_count_inc == r_num) begin
                            r_state  <= ST_DIV;
                            r_div_go <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    // The quotient is bounded by the sample maximum, so the low bits are exact.
                    if (w_div_done) begin
                        r_avg   <= DATA_W'(w_quotient);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign avg       = r_avg;
    assign err_num   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_averager.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_averager: directed scoreboard bench for seq_averager.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_seq_averager;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int ACC_W  = 20;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              start;
    logic [CNT_W-1:0]  num;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] avg;
    logic              busy;
    logic              err_num;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t_last      = 0;

    logic [DATA_W-1:0] samp[$];
    logic [DATA_W-1:0] sb[$];

    seq_averager #(
        .DATA_W      (DATA_W),
        .MAX_SAMPLES (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .num       (num),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .avg       (avg),
        .busy      (busy),
        .err_num   (err_num)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one full run from the samp queue and pushes the expected average.
    task automatic run(input int n, input bit gaps);
        int sum;
        int guard;
        logic [DATA_W-1:0] e;
        sum   = 0;
        start = 1'b1;
        num   = CNT_W'(n);
        @(negedge Clk);
        start = 1'b0;
        num   = CNT_W'($urandom_range(0, 15));
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                @(negedge Clk);
            end
            in_valid = 1'b1;
            in_data  = samp[i];
            guard    = 0;
            while (!in_ready && guard < 20) begin
                @(negedge Clk);
                guard++;
            end
            if (guard >= 20) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            @(negedge Clk);
            sum += int'(samp[i]);
        end
        in_valid = 1'b0;
        t_last   = cyc;
`ifdef AVG_ROUND_EN
        e = DATA_W'((sum + n / 2) / n);
`else
        e = DATA_W'(sum / n);
`endif
        sb.push_back(e);
        check("in_ready_drop", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic get_result(input string tag);
        int guard;
        logic [DATA_W-1:0] e;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_latency"}, cyc, t_last + ACC_W + 1);
        e = sb.pop_front();
        check({tag, "_avg"}, {16'd0, avg}, {16'd0, e});
    endtask

    initial begin
        Rst       = 1'b0;
        start     = 1'b0;
        num       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err_num}, 32'd0);
        check("rst_avg", {16'd0, avg}, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        // num=8, 10..80 -> 45
        samp = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
        run(8, 1'b0);
        get_result("avg8");
        @(negedge Clk);
        check("avg8_valid_drop", {31'd0, out_valid}, 32'd0);
        check("avg8_idle", {31'd0, busy}, 32'd0);

        // num=2, 1,2 -> 1 (2 when rounding)
        samp = '{16'd1, 16'd2};
        run(2, 1'b0);
        get_result("avg2");
        @(negedge Clk);

        // illegal counts
        start = 1'b1;
        num   = 4'd0;
        @(negedge Clk);
        start = 1'b0;
        check("err0_pulse", {31'd0, err_num}, 32'd1);
        check("err0_in_ready", {31'd0, in_ready}, 32'd0);
        check("err0_busy", {31'd0, busy}, 32'd0);
        @(negedge Clk);
        check("err0_clear", {31'd0, err_num}, 32'd0);
        start = 1'b1;
        num   = 4'd9;
        @(negedge Clk);
        start = 1'b0;
        check("err9_pulse", {31'd0, err_num}, 32'd1);
        check("err9_in_ready", {31'd0, in_ready}, 32'd0);
        check("err9_busy", {31'd0, busy}, 32'd0);
        @(negedge Clk);
        check("err9_clear", {31'd0, err_num}, 32'd0);

        // full-scale samples with gaps
        samp = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run(8, 1'b1);
        get_result("avg_max");
        @(negedge Clk);

        // consumer stall with start asserted throughout
        out_ready = 1'b0;
        samp = '{16'd5, 16'd6, 16'd7};
        run(3, 1'b0);
        get_result("stall");
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            num   = 4'd1;
            @(negedge Clk);
            check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold_avg", {16'd0, avg}, 32'd6);
        end
        out_ready = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("stall_release", {31'd0, out_valid}, 32'd0);
        check("stall_idle", {31'd0, busy}, 32'd0);
        @(negedge Clk);
        check("stall_start_ignored", {31'd0, busy}, 32'd0);

        // reset mid-run aborts
        start = 1'b1;
        num   = 4'd5;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i + 1);
            @(negedge Clk);
        end
        in_valid = 1'b0;
        #2 Rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_avg", {16'd0, avg}, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        samp = '{16'd7};
        run(1, 1'b0);
        get_result("after_abort");
        @(negedge Clk);
        check("after_abort_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
